// File: rtl/syscall_console_unit_pkg.sv
// Shared call codes, ASCII constants and types for the console syscall unit.
// Decode and hazard logic import the same call codes from here.
package syscall_console_unit_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [2:0] {
    IDLE, CHAR, CONV, SIGN, DIGIT, DISCARD, HALT
  } state_e;

  typedef struct packed {
    logic [31:0] funct;
    logic [31:0] param;
  } req_t;

  // Number of significant BCD digits in a 10-digit value; zero still prints one digit.
  function automatic logic [3:0] sig_digits(input logic [39:0] bcd);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 1; i < 10; i++) begin
      if (bcd[4*i +: 4] != 4'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/syscall_console_unit_if.sv
// Syscall request port (from execute) and console byte port (to sink).
interface syscall_console_unit_if;
  logic        syscall_valid;
  logic [31:0] syscall_funct;
  logic [31:0] syscall_param;
  logic        syscall_ready;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;

  modport master (
    output syscall_valid, syscall_funct, syscall_param, console_ready,
    input  syscall_ready, console_valid, console_data
  );

  modport slave (
    input  syscall_valid, syscall_funct, syscall_param, console_ready,
    output syscall_ready, console_valid, console_data
  );
endinterface

// File: rtl/syscall_console_unit_bin2bcd_seq.sv
// Sequential double-dabble: 32-bit unsigned to 10 BCD digits in exactly 32 cycles.
module bin2bcd_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [39:0] bcd_o
);

  logic [39:0] bcd_q;
  logic [39:0] bcd_adj;
  logic [31:0] bin_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;

  always_comb begin
    // NOTE: full default before the conditional updates keeps this block latch-free.
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        bcd_q  <= '0;
        bin_q  <= bin_i;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
        cnt_q          <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/syscall_console_unit.sv
// Console syscall unit: queues print_int/print_char/exit requests and renders
// them in order as an ASCII byte stream on a valid/ready console port.
module syscall_console_unit
  import syscall_console_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  syscall_console_unit_if.slave   bus,
  output logic                    halted,
  output logic                    unsupported
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  req_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;
  req_t             head;

  state_e      state_q;
  logic        console_valid_q;
  logic [7:0]  console_data_q;
  logic        halted_q;
  logic        unsupported_q;
  logic        neg_q;
  logic [39:0] digits_q;
  logic [3:0]  ndig_q;

  logic        bcd_start, bcd_busy, bcd_done;
  logic [39:0] bcd;
  logic [31:0] magnitude;
  logic [3:0]  bcd_ndig;
  logic [5:0]  lead_shift;

  assign bus.syscall_ready = (count_q != FULL_CNT) && !halted_q;
  assign push = bus.syscall_valid && bus.syscall_ready;
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign head = mem_q[rd_ptr_q];

  // NOTE: queue storage carries no reset; the pointers and count alone define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {bus.syscall_funct, bus.syscall_param};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Two's-complement negate of 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign magnitude = head.param[31] ? (~head.param + 32'd1) : head.param;
  assign bcd_start = pop && (head.funct == SYS_PRINT_INT);

  bin2bcd_seq u_bin2bcd (
    .clock   (clock),
    .reset   (reset),
    .start_i (bcd_start),
    .bin_i   (magnitude),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  // Left-align the result so the most significant printed digit sits in the top nibble.
  assign bcd_ndig   = sig_digits(bcd);
  assign lead_shift = 6'd40 - {bcd_ndig, 2'b00};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      console_valid_q <= 1'b0;
      console_data_q  <= '0;
      halted_q        <= 1'b0;
      unsupported_q   <= 1'b0;
      neg_q           <= 1'b0;
      digits_q        <= '0;
      ndig_q          <= '0;
    end else begin
      unsupported_q <= 1'b0;
      unique case (state_q)
        IDLE: if (pop) begin
          neg_q <= head.param[31];
          if (head.funct == SYS_PRINT_CHAR) begin
            console_valid_q <= 1'b1;
            console_data_q  <= head.param[7:0];
            state_q         <= CHAR;
          end else if (head.funct == SYS_PRINT_INT) begin
            state_q <= CONV;
          end else if (head.funct == SYS_EXIT) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            unsupported_q <= 1'b1;
            state_q       <= DISCARD;
          end
        end
        CHAR: if (bus.console_ready) begin
          console_valid_q <= 1'b0;
          state_q         <= IDLE;
        end
        CONV: if (bcd_done && !bcd_busy) begin
          ndig_q          <= bcd_ndig;
          digits_q        <= bcd << lead_shift;
          console_valid_q <= neg_q;
          console_data_q  <= ASCII_MINUS;
          state_q         <= SIGN;
        end
        SIGN: if (!console_valid_q || bus.console_ready) begin
          console_valid_q <= 1'b1;
          console_data_q  <= ASCII_0 + {4'b0000, digits_q[39:36]};
          state_q         <= DIGIT;
        end
        DIGIT: if (bus.console_ready) begin
          if (ndig_q == 4'd1) begin
            console_valid_q <= 1'b0;
            state_q         <= IDLE;
          end else begin
            console_data_q <= ASCII_0 + {4'b0000, digits_q[35:32]};
            digits_q       <= digits_q << 4;
            ndig_q         <= ndig_q - 4'd1;
          end
        end
        DISCARD: state_q <= IDLE;
        HALT:    ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.console_valid = console_valid_q;
  assign bus.console_data  = console_data_q;
  assign halted            = halted_q;
  assign unsupported       = unsupported_q;

endmodule

// File: tb/tb_syscall_console_unit.sv
// Scoreboard bench: the driver pushes expected bytes from a string-level model,
// an independent monitor pops and compares every accepted console byte.
module tb_syscall_console_unit;

  localparam logic [31:0] F_INT  = 32'd1;
  localparam logic [31:0] F_EXIT = 32'd10;
  localparam logic [31:0] F_CHAR = 32'd11;

  logic clock = 1'b0;
  logic reset;
  logic halted, unsupported;

  syscall_console_unit_if bus ();

  syscall_console_unit #(.FIFO_DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .halted      (halted),
    .unsupported (unsupported)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  bit         model_halt = 1'b0;
  int         unsup_exp  = 0;
  int         unsup_seen = 0;
  int         beats_seen = 0;
  bit         rand_ready = 1'b0;
  bit         stalled_prev = 1'b0;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Reference model: expected output of one accepted request, from the call rules.
  task automatic model_accept(input logic [31:0] f, input logic [31:0] p);
    string s;
    if (model_halt) return;
    if (f == F_CHAR) exp_q.push_back(p[7:0]);
    else if (f == F_INT) begin
      s = $sformatf("%0d", $signed(p));
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    end else if (f == F_EXIT) model_halt = 1'b1;
    else unsup_exp++;
  endtask

  // Monitor: samples on the falling edge, where inputs and DUT outputs are both settled.
  always @(negedge clock) begin
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check("hold_valid", {31'b0, bus.console_valid}, 32'd1);
        check("hold_data", {24'b0, bus.console_data}, {24'b0, prev_data});
      end
      if (bus.console_valid && bus.console_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL console_extra actual=%0h required=no_byte", bus.console_data);
        end else begin
          check("console_byte", {24'b0, bus.console_data}, {24'b0, exp_q.pop_front()});
        end
      end
      stalled_prev = bus.console_valid && !bus.console_ready;
      prev_data    = bus.console_data;
      if (unsupported) unsup_seen++;
    end
  end

  always begin
    @(posedge clock);
    #1;
    if (rand_ready) bus.console_ready = ($urandom_range(0, 3) != 0);
  end

  // Drives one request starting at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [31:0] f, input logic [31:0] p, input int bound, output bit acc);
    bus.syscall_valid = 1'b1;
    bus.syscall_funct = f;
    bus.syscall_param = p;
    acc = 1'b0;
    for (int i = 0; i < bound && !acc; i++) begin
      @(negedge clock);
      if (bus.syscall_ready) begin
        acc = 1'b1;
        model_accept(f, p);
      end
      @(posedge clock);
      #1;
    end
    bus.syscall_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 5000) begin
      @(negedge clock);
      i++;
    end
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    repeat (40) @(negedge clock);
    check({tag, "_unsupported"}, unsup_seen, unsup_exp);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    model_halt = 1'b0;
    unsup_exp  = 0;
    unsup_seen = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit acc;
    int b0, i;
    logic [31:0] f, p;

    bus.syscall_valid = 1'b0;
    bus.syscall_funct = '0;
    bus.syscall_param = '0;
    bus.console_ready = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    do_reset();

    @(negedge clock);
    check("rst_console_valid", {31'b0, bus.console_valid}, 32'd0);
    check("rst_console_data", {24'b0, bus.console_data}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_unsupported", {31'b0, unsupported}, 32'd0);
    check("rst_syscall_ready", {31'b0, bus.syscall_ready}, 32'd1);
    @(posedge clock);
    #1;

    b0 = beats_seen;
    issue(F_CHAR, 32'h41, 20, acc);
    check("t1_accept", {31'b0, acc}, 32'd1);
    @(negedge clock);
    check("t1_ready_stays", {31'b0, bus.syscall_ready}, 32'd1);
    @(posedge clock);
    #1;
    drain("t1");
    check("t1_one_beat", beats_seen - b0, 32'd1);

    issue(F_INT, -32'sd305, 20, acc);
    drain("t2");

    b0 = beats_seen;
    issue(F_INT, 32'd0, 20, acc);
    issue(F_INT, 32'h8000_0000, 200, acc);
    drain("t3");
    check("t3_beats", beats_seen - b0, 32'd12);

    b0 = beats_seen;
    issue(32'd4, 32'h1234, 20, acc);
    drain("t6_unsup");
    check("t6_no_beat", beats_seen - b0, 32'd0);

    issue(F_INT, 32'd12345, 20, acc);
    repeat (10) @(posedge clock);
    #1;
    do_reset();
    issue(F_CHAR, 32'h5A, 20, acc);
    drain("t6_reset");

    bus.console_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue(F_CHAR, 32'h61 + k, 20, acc);
      check("t4_accept", {31'b0, acc}, 32'd1);
    end
    @(negedge clock);
    check("t4_full_ready", {31'b0, bus.syscall_ready}, 32'd0);
    repeat (5) @(negedge clock);
    check("t4_none_sent", exp_q.size(), 32'd5);
    @(posedge clock);
    #1;
    bus.console_ready = 1'b1;
    drain("t4");

    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 8))
        0, 1, 2, 3: begin f = F_CHAR; p = $urandom; end
        4, 5, 6, 7: begin
          f = F_INT;
          case ($urandom_range(0, 5))
            0: p = $urandom;
            1: p = 32'd0;
            2: p = 32'h8000_0000;
            3: p = 32'h7FFF_FFFF;
            4: p = 32'hFFFF_FFFF;
            default: p = ($urandom_range(0, 1) != 0) ? -($urandom_range(0, 999)) : $urandom_range(0, 999);
          endcase
        end
        default: begin
          f = $urandom;
          if (f == F_INT || f == F_EXIT || f == F_CHAR) f = 32'd4;
          p = $urandom;
        end
      endcase
      issue(f, p, 2000, acc);
      check("rand_accept", {31'b0, acc}, 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    drain("rand");
    rand_ready = 1'b0;
    @(posedge clock);
    #1;
    bus.console_ready = 1'b1;

    issue(F_CHAR, 32'h41, 20, acc);
    issue(F_EXIT, 32'd0, 20, acc);
    i = 0;
    while (!halted && i < 100) begin
      @(negedge clock);
      i++;
    end
    check("t5_halted", {31'b0, halted}, 32'd1);
    check("t5_char_first", exp_q.size(), 32'd0);
    check("t5_ready_low", {31'b0, bus.syscall_ready}, 32'd0);
    @(posedge clock);
    #1;
    b0 = beats_seen;
    issue(F_CHAR, 32'h71, 8, acc);
    check("t5_blocked", {31'b0, acc}, 32'd0);
    drain("t5");
    check("t5_no_beat", beats_seen - b0, 32'd0);
    check("t5_still_halted", {31'b0, halted}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
